control_unit_seq: RTL and testbench

- Registered, stall/flush-aware successor of the ID-stage control decoder.
- Decodes {mode, op_code, S} into EX-stage control signals and registers them at the ID/EX boundary.
- Gates side effects on the condition-check result.
- Adds a sequenced block-transfer mode (mode 2'b11, LDM/STM-style) that issues N memory beats over N cycles while back-pressuring fetch/decode.

---
 rtl/control_unit_seq.sv | 199 +++++++++++++++++++
 tb/tb_control_unit_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_seq.sv
// Registered ID/EX control decoder with condition annul, stall/flush handling
// and a sequenced multi-beat block-transfer mode.
module control_unit_seq #(
  parameter int unsigned EX_CMD_W = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                S,
  input  logic [1:0]          mode,
  input  logic [3:0]          op_code,
  input  logic [CNT_W-1:0]    reg_count,
  input  logic                cond_pass,
  input  logic                stall,
  input  logic                flush,
  output logic                out_valid,
  output logic [EX_CMD_W-1:0] EX_command,
  output logic                mem_read,
  output logic                mem_write,
  output logic                WB_en,
  output logic                B,
  output logic                SR_update,
  output logic                has_src1,
  output logic [CNT_W-1:0]    beat_idx,
  output logic                last_beat,
  output logic                illegal
);

  typedef enum logic {IDLE, BURST} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic                valid_q, valid_d;
  logic [EX_CMD_W-1:0] cmd_q, cmd_d;
  logic                mr_q, mr_d, mw_q, mw_d, wb_q, wb_d;
  logic                b_q, b_d, sr_q, sr_d, hs_q, hs_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic                last_q, last_d, ill_q, ill_d;

  logic [EX_CMD_W-1:0] dec_cmd;
  logic                dec_mr, dec_mw, dec_wb, dec_b, dec_sr, dec_hs, dec_ill;
  logic                burst_go;

  assign in_ready = (state_q == IDLE) && !stall;

  // Instruction decode, with side effects annulled on a failed condition.
  always_comb begin
    dec_cmd = '0;
    dec_mr  = 1'b0;
    dec_mw  = 1'b0;
    dec_wb  = 1'b0;
    dec_b   = 1'b0;
    dec_sr  = 1'b0;
    dec_hs  = 1'b1;
    dec_ill = 1'b0;
    unique case (mode)
      2'b00: begin
        dec_sr = S;
        dec_wb = 1'b1;
        unique case (op_code)
          4'b1101: begin dec_cmd = EX_CMD_W'(4'b0001); dec_hs = 1'b0; end
          4'b1111: begin dec_cmd = EX_CMD_W'(4'b1001); dec_hs = 1'b0; end
          4'b0100: dec_cmd = EX_CMD_W'(4'b0010);
          4'b0101: dec_cmd = EX_CMD_W'(4'b0011);
          4'b0010: dec_cmd = EX_CMD_W'(4'b0100);
          4'b0110: dec_cmd = EX_CMD_W'(4'b0101);
          4'b0000: dec_cmd = EX_CMD_W'(4'b0110);
          4'b1100: dec_cmd = EX_CMD_W'(4'b0111);
          4'b0001: dec_cmd = EX_CMD_W'(4'b1000);
          4'b1010: begin dec_cmd = EX_CMD_W'(4'b0100); dec_wb = 1'b0; end
          4'b1000: begin dec_cmd = EX_CMD_W'(4'b0110); dec_wb = 1'b0; end
          default: begin dec_wb = 1'b0; dec_ill = 1'b1; end
        endcase
      end
      2'b10: begin
        dec_b  = 1'b1;
        dec_hs = 1'b0;
      end
      default: begin
        dec_cmd = EX_CMD_W'(4'b0010);
        dec_mr  = S;
        dec_wb  = S;
        dec_mw  = !S;
      end
    endcase
    if (!cond_pass) begin
      dec_mr  = 1'b0;
      dec_mw  = 1'b0;
      dec_wb  = 1'b0;
      dec_b   = 1'b0;
      dec_sr  = 1'b0;
      dec_ill = 1'b0;
    end
  end

  // Multi-beat sequencing only when the block transfer is actually executed.
  assign burst_go = (mode == 2'b11) && cond_pass && (reg_count != '0);

  // Next state and next output bundle: flush > stall > burst beat > accept > idle.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    cmd_d   = cmd_q;
    mr_d    = mr_q;
    mw_d    = mw_q;
    wb_d    = wb_q;
    b_d     = b_q;
    sr_d    = sr_q;
    hs_d    = hs_q;
    idx_d   = idx_q;
    last_d  = last_q;
    ill_d   = ill_q;
    if (flush) begin
      state_d = IDLE;
      rem_d   = '0;
      valid_d = 1'b0;
      cmd_d   = '0;
      {mr_d, mw_d, wb_d, b_d, sr_d, hs_d, last_d, ill_d} = '0;
      idx_d   = '0;
    end else if (stall) begin
      // hold everything
    end else if (state_q == BURST) begin
      // rem_q counts beats still to issue after the one on the outputs;
      // memory controls are reused from the held bundle.
      idx_d  = idx_q + CNT_W'(1);
      rem_d  = rem_q - CNT_W'(1);
      last_d = (rem_q == CNT_W'(1));
      if (rem_q == CNT_W'(1)) state_d = IDLE;
    end else if (in_valid) begin
      valid_d = 1'b1;
      cmd_d   = dec_cmd;
      mr_d    = dec_mr;
      mw_d    = dec_mw;
      wb_d    = dec_wb;
      b_d     = dec_b;
      sr_d    = dec_sr;
      hs_d    = dec_hs;
      ill_d   = dec_ill;
      idx_d   = '0;
      last_d  = !burst_go;
      state_d = burst_go ? BURST : IDLE;
      rem_d   = burst_go ? reg_count : '0;
    end else begin
      valid_d = 1'b0;
      cmd_d   = '0;
      {mr_d, mw_d, wb_d, b_d, sr_d, hs_d, last_d, ill_d} = '0;
      idx_d   = '0;
    end
  end

  // ID/EX boundary registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      valid_q <= 1'b0;
      cmd_q   <= '0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      wb_q    <= 1'b0;
      b_q     <= 1'b0;
      sr_q    <= 1'b0;
      hs_q    <= 1'b0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      cmd_q   <= cmd_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      wb_q    <= wb_d;
      b_q     <= b_d;
      sr_q    <= sr_d;
      hs_q    <= hs_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      ill_q   <= ill_d;
    end
  end

  assign out_valid  = valid_q;
  assign EX_command = cmd_q;
  assign mem_read   = mr_q;
  assign mem_write  = mw_q;
  assign WB_en      = wb_q;
  assign B          = b_q;
  assign SR_update  = sr_q;
  assign has_src1   = hs_q;
  assign beat_idx   = idx_q;
  assign last_beat  = last_q;
  assign illegal    = ill_q;

endmodule

// File: tb/tb_control_unit_seq.sv
// Bench for control_unit_seq: queue-based reference model plus directed pins.
module tb_control_unit_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0, S = 1'b0, cond_pass = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] op_code = 4'h0, reg_count = 4'h0;
  logic       in_ready, out_valid, mem_read, mem_write, WB_en, B, SR_update;
  logic       has_src1, last_beat, illegal;
  logic [3:0] EX_command, beat_idx;

  control_unit_seq #(.EX_CMD_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .S(S),
    .mode(mode), .op_code(op_code), .reg_count(reg_count), .cond_pass(cond_pass),
    .stall(stall), .flush(flush), .out_valid(out_valid), .EX_command(EX_command),
    .mem_read(mem_read), .mem_write(mem_write), .WB_en(WB_en), .B(B),
    .SR_update(SR_update), .has_src1(has_src1), .beat_idx(beat_idx),
    .last_beat(last_beat), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [3:0] cmd;
    logic       mr, mw, wb, b, sr, hs;
    logic [3:0] idx;
    logic       last, ill;
  } bundle_t;

  int      vectors = 0;
  int      miscompares = 0;
  bit      run = 1'b1;
  bundle_t cur;
  bundle_t pend[$];
  bundle_t dut_b;
  logic [3:0] cmd_tab[16];
  logic       wb_tab[16];
  logic       legal[16];

  assign dut_b = '{v: out_valid, cmd: EX_command, mr: mem_read, mw: mem_write,
                   wb: WB_en, b: B, sr: SR_update, hs: has_src1, idx: beat_idx,
                   last: last_beat, ill: illegal};

  initial begin
    for (int i = 0; i < 16; i++) begin
      cmd_tab[i] = 4'h0; wb_tab[i] = 1'b0; legal[i] = 1'b0;
    end
    cmd_tab[13] = 4'h1; cmd_tab[15] = 4'h9; cmd_tab[4] = 4'h2; cmd_tab[5] = 4'h3;
    cmd_tab[2]  = 4'h4; cmd_tab[6]  = 4'h5; cmd_tab[0] = 4'h6; cmd_tab[12] = 4'h7;
    cmd_tab[1]  = 4'h8; cmd_tab[10] = 4'h4; cmd_tab[8] = 4'h6;
    foreach (legal[i]) legal[i] = (i inside {13, 15, 4, 5, 2, 6, 0, 12, 1, 10, 8});
    foreach (wb_tab[i]) wb_tab[i] = legal[i] && !(i inside {10, 8});
  end

  function automatic bundle_t beat(input logic [1:0] md, input logic [3:0] op,
                                   input logic s, input logic cp,
                                   input int idx, input logic last);
    bundle_t r = '0;
    r.v = 1'b1; r.idx = 4'(idx); r.last = last; r.hs = 1'b1;
    if (md == 2'b00) begin
      r.cmd = cmd_tab[op]; r.wb = wb_tab[op]; r.ill = !legal[op]; r.sr = s;
      r.hs = !(op == 4'd13 || op == 4'd15);
    end else if (md == 2'b10) begin
      r.b = 1'b1; r.hs = 1'b0;
    end else begin
      r.cmd = 4'h2; r.mr = s; r.wb = s; r.mw = !s;
    end
    if (!cp) begin
      r.mr = 0; r.mw = 0; r.wb = 0; r.b = 0; r.sr = 0; r.ill = 0;
    end
    return r;
  endfunction

  // Reference: cur is what the outputs show, pend holds beats yet to be issued.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur = '0; pend.delete();
    end else if (flush) begin
      cur = '0; pend.delete();
    end else if (stall) begin
    end else if (pend.size() != 0) begin
      cur = pend.pop_front();
    end else if (in_valid) begin
      int n;
      n = (mode == 2'b11 && cond_pass) ? int'(reg_count) + 1 : 1;
      for (int i = 0; i < n; i++) pend.push_back(beat(mode, op_code, S, cond_pass, i, i == n - 1));
      cur = pend.pop_front();
    end else begin
      cur = '0;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      vectors++;
      if (dut_b !== cur) begin
        miscompares++;
        $display("FAIL bundle t=%0t got=%h exp=%h", $time, dut_b, cur);
      end
      vectors++;
      if (in_ready !== (pend.size() == 0 && !stall)) begin
        miscompares++;
        $display("FAIL in_ready t=%0t got=%b exp=%b", $time, in_ready, (pend.size() == 0 && !stall));
      end
    end
  end

  task automatic lit(input string nm, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [1:0] md, input logic [3:0] op,
                     input logic s, input logic [3:0] rc, input logic cp);
    in_valid = v; mode = md; op_code = op; S = s; reg_count = rc; cond_pass = cp;
  endtask

  task automatic tick;
    @(posedge clk); @(negedge clk); #1;
  endtask

  initial begin
    tick; tick;
    lit("rst_valid", 8'(out_valid), 8'd0);
    lit("rst_ready", 8'(in_ready), 8'd1);
    rst = 1'b1;
    // ADD
    drv(1, 2'b00, 4'b0100, 1, 0, 1); tick;
    lit("add_valid", 8'(out_valid), 8'd1); lit("add_cmd", 8'(EX_command), 8'h2);
    lit("add_wb", 8'(WB_en), 8'd1); lit("add_sr", 8'(SR_update), 8'd1);
    lit("add_hs", 8'(has_src1), 8'd1); lit("add_last", 8'(last_beat), 8'd1);
    // MOV annulled
    drv(1, 2'b00, 4'b1101, 1, 0, 0); tick;
    lit("mov_valid", 8'(out_valid), 8'd1); lit("mov_cmd", 8'(EX_command), 8'h1);
    lit("mov_wb", 8'(WB_en), 8'd0); lit("mov_sr", 8'(SR_update), 8'd0);
    lit("mov_hs", 8'(has_src1), 8'd0);
    // undefined opcode
    drv(1, 2'b00, 4'b0011, 0, 0, 1); tick;
    lit("ill", 8'(illegal), 8'd1); lit("ill_cmd", 8'(EX_command), 8'h0);
    lit("ill_wb", 8'(WB_en), 8'd0);
    // block load, 4 beats
    drv(1, 2'b11, 4'h0, 1, 4'd3, 1); tick;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lit("bl_idx", 8'(beat_idx), 8'(i)); lit("bl_mr", 8'(mem_read), 8'd1);
      lit("bl_wb", 8'(WB_en), 8'd1); lit("bl_rdy", 8'(in_ready), 8'(i == 3));
      lit("bl_last", 8'(last_beat), 8'(i == 3));
      if (i < 3) tick;
    end
    tick;
    lit("bl_done", 8'(out_valid), 8'd0);
    // block store with 2-cycle stall after beat 0
    drv(1, 2'b11, 4'h0, 0, 4'd2, 1); tick;
    in_valid = 1'b0; stall = 1'b1;
    lit("bs_b0", 8'(beat_idx), 8'd0);
    tick; lit("bs_h1", 8'(beat_idx), 8'd0); lit("bs_mw", 8'(mem_write), 8'd1);
    tick; lit("bs_h2", 8'(beat_idx), 8'd0);
    stall = 1'b0;
    tick; lit("bs_b1", 8'(beat_idx), 8'd1); lit("bs_mw1", 8'(mem_write), 8'd1);
    tick; lit("bs_b2", 8'(beat_idx), 8'd2); lit("bs_last", 8'(last_beat), 8'd1);
    // flush during beat 1 while stalled
    drv(1, 2'b11, 4'h0, 1, 4'd3, 1); tick;
    in_valid = 1'b0; tick;
    lit("fl_b1", 8'(beat_idx), 8'd1);
    stall = 1'b1; flush = 1'b1; tick;
    lit("fl_valid", 8'(out_valid), 8'd0);
    stall = 1'b0; flush = 1'b0; #1;
    lit("fl_ready", 8'(in_ready), 8'd1);
    tick; lit("fl_none", 8'(out_valid), 8'd0);
    // asynchronous reset mid-burst
    drv(1, 2'b11, 4'h0, 1, 4'd3, 1); tick;
    in_valid = 1'b0; tick;
    rst = 1'b0; #1;
    lit("ar_valid", 8'(out_valid), 8'd0); lit("ar_mr", 8'(mem_read), 8'd0);
    lit("ar_idx", 8'(beat_idx), 8'd0);
    tick; rst = 1'b1;
    // branch then LDR back to back
    drv(1, 2'b10, 4'h0, 0, 0, 1); tick;
    lit("br_b", 8'(B), 8'd1); lit("br_hs", 8'(has_src1), 8'd0);
    drv(1, 2'b01, 4'h0, 1, 0, 1); tick;
    lit("ldr_mr", 8'(mem_read), 8'd1); lit("ldr_wb", 8'(WB_en), 8'd1);
    lit("ldr_cmd", 8'(EX_command), 8'h2); lit("ldr_b", 8'(B), 8'd0);
    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      drv($urandom_range(0, 99) < 70, 2'($urandom), 4'($urandom),
          1'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 4)),
          $urandom_range(0, 99) < 80);
      stall = $urandom_range(0, 99) < 20;
      flush = $urandom_range(0, 99) < 5;
      rst   = $urandom_range(0, 199) != 0;
      tick;
    end
    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
